merge_arb_4: RTL and testbench

MERGE_ARB_4 -- requirements
Module: merge_arb_4

---
 rtl/merge_arb_4.sv | 156 +++++++++++++++
 tb/tb_merge_arb_4.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_arb_4.sv
// merge_arb_4 -- four-input packet merge with round-robin arbitration.
//
// Each source port owns a one-entry holding buffer. Full buffers compete for
// a single registered output stage. The search starts at the round-robin
// pointer, and the pointer advances to one past the last winner. Packets pass
// through unmodified, and out_src tags the port each packet came from.
//
// Ports:
//   clk                      single clock, rising edge
//   rst                      asynchronous active-low reset
//   A/B/C/D_data [WIDTH]     packet from source port 0/1/2/3
//   A/B/C/D_valid            source port presents a packet
//   A/B/C/D_ready            port buffer is empty and can capture this cycle
//   out_data [WIDTH]         merged packet
//   out_valid                out_data holds a packet
//   out_ready                downstream accepts out_data this cycle
//   out_src [2]              originating port of out_data (0=A .. 3=D)
//   pkt_count [16]           completed output handshakes, wrapping
module merge_arb_4 #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_data,
  input  logic [WIDTH-1:0] B_data,
  input  logic [WIDTH-1:0] C_data,
  input  logic [WIDTH-1:0] D_data,
  input  logic             A_valid,
  input  logic             B_valid,
  input  logic             C_valid,
  input  logic             D_valid,
  output logic             A_ready,
  output logic             B_ready,
  output logic             C_ready,
  output logic             D_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_src,
  output logic [15:0]      pkt_count
);

  logic [WIDTH-1:0] in_data [4];
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;

  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];
  logic [3:0]       full_q, full_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_src_q, out_src_d;
  logic [1:0]       rr_q, rr_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             load;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       idx;

  assign in_data[0] = A_data;
  assign in_data[1] = B_data;
  assign in_data[2] = C_data;
  assign in_data[3] = D_data;
  assign in_valid   = {D_valid, C_valid, B_valid, A_valid};

  // Gating with rst keeps every ready low for the whole time reset is held,
  // not only after the first clock edge.
  assign in_ready = {4{rst}} & ~full_q;
  assign A_ready  = in_ready[0];
  assign B_ready  = in_ready[1];
  assign C_ready  = in_ready[2];
  assign D_ready  = in_ready[3];

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign pkt_count = cnt_q;

  // The output register can take a new packet when it is empty or when its
  // current packet leaves this cycle.
  assign load = ~out_valid_q | out_ready;

  // Scan the ports in the order rr_q, rr_q+1, rr_q+2, rr_q+3 (mod 4).
  // The first full buffer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    idx       = rr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!win_found && full_q[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    buf_d       = buf_q;
    full_d      = full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;

    if (out_valid_q && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (load) begin
      if (win_found) begin
        out_data_d      = buf_q[win_idx];
        out_src_d       = win_idx;
        out_valid_d     = 1'b1;
        full_d[win_idx] = 1'b0;
        rr_d            = win_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A buffer granted this cycle had ready=0, so it cannot also capture.
    // Its ready rises in the following cycle.
    for (int p = 0; p < 4; p++) begin
      if (in_valid[p] && in_ready[p]) begin
        buf_d[p]  = in_data[p];
        full_d[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        buf_q[p] <= '0;
      end
      full_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
    end else begin
      buf_q       <= buf_d;
      full_q      <= full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_merge_arb_4.sv
module tb_merge_arb_4;

  localparam int WIDTH = 34;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data [4];
  logic             in_valid [4];
  logic             A_ready, B_ready, C_ready, D_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_src;
  logic [15:0]      pkt_count;

  merge_arb_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .A_data    (in_data[0]),
    .B_data    (in_data[1]),
    .C_data    (in_data[2]),
    .D_data    (in_data[3]),
    .A_valid   (in_valid[0]),
    .B_valid   (in_valid[1]),
    .C_valid   (in_valid[2]),
    .D_valid   (in_valid[3]),
    .A_ready   (A_ready),
    .B_ready   (B_ready),
    .C_ready   (C_ready),
    .D_ready   (D_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural reference: one slot per port plus a presented packet.
  bit               m_full [4];
  logic [WIDTH-1:0] m_slot [4];
  bit               m_ov;
  logic [WIDTH-1:0] m_od;
  int               m_src;
  int               m_ptr;
  int               m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_full[p] = 0;
      m_slot[p] = '0;
    end
    m_ov = 0; m_od = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Advance the model by one rising edge, using the inputs as they are now.
  task automatic model_edge();
    bit took [4];
    int g;
    for (int p = 0; p < 4; p++) took[p] = in_valid[p] && !m_full[p];
    if (m_ov && out_ready) m_cnt = (m_cnt + 1) % 65536;
    if (!m_ov || out_ready) begin
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && m_full[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      if (g >= 0) begin
        m_od = m_slot[g]; m_src = g; m_ov = 1;
        m_full[g] = 0; m_ptr = (g + 1) % 4;
      end else begin
        m_ov = 0;
      end
    end
    for (int p = 0; p < 4; p++)
      if (took[p]) begin
        m_slot[p] = in_data[p];
        m_full[p] = 1;
      end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] rdy_exp;
    for (int p = 0; p < 4; p++) rdy_exp[p] = rst && !m_full[p];
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, ".pkt_count"}, 64'(pkt_count), 64'(m_cnt));
    chk({tag, ".ready"}, 64'({D_ready, C_ready, B_ready, A_ready}), 64'(rdy_exp));
    if (m_ov) begin
      chk({tag, ".out_data"}, 64'(out_data), 64'(m_od));
      chk({tag, ".out_src"}, 64'(out_src), 64'(m_src));
    end
  endtask

  task automatic step(input string tag);
    if (rst) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 4; p++) begin
      in_valid[p] = 1'b0;
      in_data[p]  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    idle_inputs();
    step("reset");
    step("reset");
    rst = 1'b1;
    #1;
    chk("rst_release_ready", 64'({D_ready, C_ready, B_ready, A_ready}), 64'hF);
  endtask

  function automatic logic [WIDTH-1:0] rnd_data();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[WIDTH-1:0];
  endfunction

  initial begin
    logic [WIDTH-1:0] a1, a2, cd;
    int guard;

    rst = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    chk("reset.out_valid", 64'(out_valid), 64'h0);
    chk("reset.out_data", 64'(out_data), 64'h0);
    chk("reset.pkt_count", 64'(pkt_count), 64'h0);
    chk("reset.ready", 64'({D_ready, C_ready, B_ready, A_ready}), 64'h0);
    do_reset();

    // Single packet on B.
    out_ready = 1'b1;
    in_data[1] = 34'h2_0000_0005; in_valid[1] = 1'b1;
    step("single.cap");
    idle_inputs();
    step("single.grant");
    chk("single.out_valid", 64'(out_valid), 64'h1);
    chk("single.out_data", 64'(out_data), 64'h2_0000_0005);
    chk("single.out_src", 64'(out_src), 64'h1);
    step("single.drain");
    chk("single.pkt_count", 64'(pkt_count), 64'h1);

    // All four ports at the same edge.
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      in_valid[p] = 1'b1;
      in_data[p]  = WIDTH'(64'h1_0000_0000 + p * 17);
    end
    step("all4.cap");
    idle_inputs();
    for (int p = 0; p < 4; p++) begin
      step("all4.out");
      chk("all4.out_src", 64'(out_src), 64'(p));
      chk("all4.out_data", 64'(out_data), 64'h1_0000_0000 + 64'(p * 17));
    end
    step("all4.end");
    chk("all4.pkt_count", 64'(pkt_count), 64'h4);
    chk("all4.out_valid", 64'(out_valid), 64'h0);

    // Backpressure with A and C full.
    do_reset();
    out_ready = 1'b0;
    a1 = rnd_data(); a2 = rnd_data(); cd = rnd_data();
    in_valid[0] = 1'b1; in_data[0] = a1;
    in_valid[2] = 1'b1; in_data[2] = cd;
    step("bp.cap");
    in_valid[2] = 1'b0; in_data[0] = a2;
    step("bp.grant");
    step("bp.refill");
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("bp.hold");
      chk("bp.out_data", 64'(out_data), 64'(a1));
      chk("bp.out_src", 64'(out_src), 64'h0);
      chk("bp.AC_ready", 64'({C_ready, A_ready}), 64'h0);
    end
    out_ready = 1'b1;
    step("bp.drain1");
    chk("bp.drainC", 64'(out_data), 64'(cd));
    step("bp.drain2");
    chk("bp.drainA", 64'(out_data), 64'(a2));

    // Fairness: A and D always valid.
    do_reset();
    out_ready = 1'b1;
    in_valid[0] = 1'b1; in_valid[3] = 1'b1;
    step("fair.cap");
    for (int i = 0; i < 8; i++) begin
      in_data[0] = rnd_data(); in_data[3] = rnd_data();
      step("fair");
      chk("fair.out_src", 64'(out_src), (i % 2 == 0) ? 64'h0 : 64'h3);
    end

    // Reset during operation: out_valid=1 with B and C still full.
    idle_inputs();
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      in_valid[p] = 1'b1; in_data[p] = rnd_data();
    end
    step("rst_op.cap");
    idle_inputs();
    step("rst_op.grant");
    chk("rst_op.pre_valid", 64'(out_valid), 64'h1);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_op.out_valid", 64'(out_valid), 64'h0);
    chk("rst_op.ready", 64'({D_ready, C_ready, B_ready, A_ready}), 64'h0);
    chk("rst_op.out_data", 64'(out_data), 64'h0);
    model_reset();
    for (int p = 0; p < 4; p++) in_valid[p] = 1'b1;
    step("rst_op.held");
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_op.release_ready", 64'({D_ready, C_ready, B_ready, A_ready}), 64'hF);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("rst_op.quiet");
      chk("rst_op.quiet_valid", 64'(out_valid), 64'h0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 4; p++) begin
        in_valid[p] = ($urandom_range(0, 1) == 1);
        in_data[p]  = rnd_data();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step("rand");
    end

    // Counter wrap: reach 0xFFFF, then two more handshakes.
    idle_inputs();
    do_reset();
    out_ready = 1'b1;
    in_valid[0] = 1'b1; in_valid[3] = 1'b1;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      in_data[0] = WIDTH'(guard);
      in_data[3] = WIDTH'(guard + 1);
      step("wrap.run");
      guard++;
    end
    chk("wrap.bound", 64'(m_cnt), 64'hFFFF);
    chk("wrap.ffff", 64'(pkt_count), 64'hFFFF);
    step("wrap.one");
    chk("wrap.zero", 64'(pkt_count), 64'h0);
    step("wrap.two");
    chk("wrap.one", 64'(pkt_count), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
